// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one byte-wide memory between the instruction-fetch
// port and the load/store data port. Each granted request is sequenced as
// 1, 2 or 4 little-endian byte cycles, followed by a one-cycle acknowledge
// carrying the assembled (and, for data loads, extended) word.
module rv_mem_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter bit          FETCH_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_req,
  input  logic [XLEN-1:0] f_addr,
  output logic            f_ack,
  output logic [XLEN-1:0] f_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [1:0]      d_size,
  input  logic            d_unsigned,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nx;

  // Latched transaction
  logic            owner_d;   // 1 = data port owns the transaction
  logic            last_d;    // 1 = data port was granted last
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] wdata;
  logic            we;
  logic [1:0]      size;
  logic            uns;
  logic [2:0]      nbytes;
  logic [1:0]      cnt;
  logic [7:0]      lane [4];

  // Arbitration decision (valid in IDLE only)
  logic            grant;
  logic            grant_d;
  logic            last_byte;

  // Assembled load result
  logic [31:0]     word;
  logic [XLEN-1:0] load_val;

  assign last_byte = ({1'b0, cnt} == (nbytes - 3'd1));

  // Next-state and arbitration: round-robin on a tie, by last granted port
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (f_req || d_req) begin
          grant    = 1'b1;
          grant_d  = d_req && (!f_req || !last_d);
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (last_byte) begin
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register, transaction latch, byte counter and load byte buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_d  <= FETCH_FIRST;
      owner_d <= 1'b0;
      base    <= '0;
      wdata   <= '0;
      we      <= 1'b0;
      size    <= '0;
      uns     <= 1'b0;
      nbytes  <= 3'd1;
      for (int unsigned i = 0; i < 4; i++) begin
        lane[i] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant) begin
            owner_d <= grant_d;
            cnt     <= '0;
            if (grant_d) begin
              base  <= d_addr;
              we    <= d_we;
              size  <= d_size;
              uns   <= d_unsigned;
              wdata <= d_wdata;
              case (d_size)
                2'b00:   nbytes <= 3'd1;
                2'b01:   nbytes <= 3'd2;
                default: nbytes <= 3'd4;
              endcase
            end else begin
              base   <= f_addr;
              we     <= 1'b0;
              size   <= 2'b10;
              uns    <= 1'b1;
              wdata  <= '0;
              nbytes <= 3'd4;
            end
          end
        end
        BUSY: begin
          if (!we) begin
            lane[cnt] <= mem_rdata;
          end
          if (!last_byte) begin
            cnt <= cnt + 2'd1;
          end
        end
        ACK: begin
          last_d <= owner_d;
        end
        default: begin
        end
      endcase
    end
  end

  // Assemble buffered bytes and apply sign/zero extension by size
  always_comb begin
    word     = {lane[3], lane[2], lane[1], lane[0]};
    load_val = '0;
    case (size)
      2'b00: begin
        if (uns) load_val = XLEN'(lane[0]);
        else     load_val = XLEN'($signed(lane[0]));
      end
      2'b01: begin
        if (uns) load_val = XLEN'(word[15:0]);
        else     load_val = XLEN'($signed(word[15:0]));
      end
      default: begin
        if (uns) load_val = XLEN'(word);
        else     load_val = XLEN'($signed(word));
      end
    endcase
  end

  // Memory and requester outputs; reset suppresses write strobe and acks
  // in the cycle it is asserted so an aborted transfer writes no more bytes
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    f_rdata   = '0;
    d_rdata   = '0;
    busy      = (state == BUSY) || (state == ACK);
    case (state)
      BUSY: begin
        mem_addr = base + XLEN'(cnt);
        if (we) begin
          mem_we    = !rst;
          mem_wdata = wdata[8*cnt +: 8];
        end
      end
      ACK: begin
        if (!rst) begin
          if (owner_d) begin
            d_ack = 1'b1;
            if (!we) d_rdata = load_val;
          end else begin
            f_ack   = 1'b1;
            f_rdata = XLEN'(word);
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares the core's single byte-wide memory between the instruction-fetch port and the load/store data port.
- Each granted request is sequenced as 1, 2 or 4 consecutive byte cycles, little-endian.
- Load data is assembled and extended; the requester gets a one-cycle acknowledge.
- Sits between the rv control unit and the byte-array memory.

Parameters:
- XLEN, 32, width of addresses and data words.
- FETCH_FIRST, 1, if 1 the fetch port wins the first tie after reset; if 0 the data port does.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  XLEN  fetch byte address; stable while f_req is high.
- f_ack  out  1  one-cycle pulse; f_rdata is valid in the same cycle.
- f_rdata  out  XLEN  fetched instruction word.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- d_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- d_addr  in  XLEN  data byte address; stable while d_req is high.
- d_wdata  in  XLEN  store data (low bytes used for byte and half).
- d_ack  out  1  one-cycle pulse; d_rdata is valid in the same cycle.
- d_rdata  out  XLEN  extended load data; 0 for stores.
- mem_addr  out  XLEN  byte address to memory.
- mem_we  out  1  byte write strobe; the write happens at the rising edge.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  combinational read of mem[mem_addr].
- busy  out  1  high in BUSY and ACK.

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE, cnt = 0.
  - f_ack, d_ack, mem_we, busy = 0; mem_addr, mem_wdata, f_rdata, d_rdata = 0.
  - last_grant = data if FETCH_FIRST = 1, else fetch.
- Reset mid-operation aborts the transfer with no ack. Store bytes already written stay in memory.
- States: IDLE -> BUSY -> ACK -> IDLE.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not last_grant (round-robin).
  - On grant, latch owner, base address, we, size, unsigned and wdata. Set nbytes = 1, 2 or 4 (fetch is always 4). Set cnt = 0 and go to BUSY.
- BUSY, one byte per cycle:
  - mem_addr = base + cnt, modulo 2^XLEN (wraps past 0xFFFFFFFF).
  - Load: the byte buffer captures mem_rdata into byte lane cnt at the rising edge.
  - Store: mem_we = 1, mem_wdata = wdata[8*cnt +: 8].
  - When cnt == nbytes-1, go to ACK; otherwise cnt increments.
  - Misaligned addresses are not faulted; the bytes are simply sequenced.
- ACK, one cycle:
  - Owner's ack = 1 and rdata is driven from the buffer.
  - Byte and half loads are extended per d_unsigned.
  - last_grant = owner; next state is IDLE.
- Requester obligations:
  - Drop req at the same edge it samples ack; IDLE samples req on the following cycle.
  - A req still high at that point is a new request.
- Outside BUSY: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- f_rdata and d_rdata are 0 except during their own ACK cycle.
- Latency, counting from the IDLE cycle in which req is sampled (cycle 0):
  - word: ack in cycle 5.
  - half: ack in cycle 3.
  - byte: ack in cycle 2.
- A request that arrives while the block is busy waits. The losing port of a tie is served immediately after the current transaction; there is no starvation.
- Only one transaction is in flight at a time; there is no pipelining.

Test Plan:
- Fetch word: mem[0x10..0x13] = 13,05,a0,00; f_req at f_addr 0x10 -> mem_addr steps 0x10..0x13; f_ack in cycle 5 with f_rdata = 0x00a00513; d_ack stays 0.
- Store then load:
  - Store word 0xdeadbeef at 0x40 -> mem[0x40..0x43] = ef,be,ad,de and d_ack in cycle 5.
  - Signed byte load at 0x43 -> d_rdata = 0xffffffde, ack in cycle 2.
  - Unsigned half load at 0x42 -> d_rdata = 0x0000dead, ack in cycle 3.
- Tie:
  - f_req and d_req rise together after reset with FETCH_FIRST = 1 -> fetch served first, then data.
  - Repeat the tie -> the grant alternates each time; neither ack is ever lost.
- Wrap and misalignment: load word at 0xfffffffe -> mem_addr = 0xfffffffe, 0xffffffff, 0x0, 0x1; d_rdata assembled in that byte order.
- Reset mid-store: store word 0x11223344 at 0x80; assert rst during BUSY at cnt = 2 -> mem[0x80..0x81] = 44,33, mem[0x82..0x83] unchanged, no d_ack, next cycle all outputs 0 and state IDLE.
- Back-to-back: d_req held high through d_ack -> the next cycle is IDLE, then a second transaction starts. mem_we is never asserted outside BUSY.
